// File: rtl/bp_accuracy_monitor_if.sv
// Tap bundle for the branch predictor's prediction and resolve ports.
// The predictor side (or a bench) drives through the master modport.
// The monitor only observes, through the slave modport.
//   pred_valid/pred_pc/pred_taken          : prediction issued this cycle
//   resolve_valid/resolve_pc/resolve_taken : oldest outstanding branch resolves
interface bp_accuracy_monitor_if #(
  parameter int PC_WIDTH = 10
) ();
  logic                pred_valid;
  logic [PC_WIDTH-1:0] pred_pc;
  logic                pred_taken;
  logic                resolve_valid;
  logic [PC_WIDTH-1:0] resolve_pc;
  logic                resolve_taken;

  modport master (
    output pred_valid, pred_pc, pred_taken,
    output resolve_valid, resolve_pc, resolve_taken
  );

  modport slave (
    input pred_valid, pred_pc, pred_taken,
    input resolve_valid, resolve_pc, resolve_taken
  );
endinterface

// File: rtl/bp_accuracy_monitor.sv
// Runtime accuracy monitor for the tournament branch predictor.
// Each prediction is pushed into an in-order buffer and is popped when its
// resolution arrives. Matched resolutions update saturating totals and a
// windowed misprediction rate. The windowed rate drives a hysteretic alarm.
// Protocol violations latch sticky error flags.
// Ports:
//   clk_i, rst_i                : clock, synchronous active-high reset
//   bp_if (slave)               : prediction / resolve taps
//   fifo_count_o                : outstanding predictions
//   total_count_o               : matched resolutions (saturating)
//   mispredict_count_o          : matched mispredictions (saturating)
//   last_window_mispredicts_o   : mispredicts in the last completed window
//   alarm_o                     : high while the FSM is in ALARM
//   pc_mismatch_err_o           : sticky, resolve PC differed from head PC
//   overflow_err_o              : sticky, push dropped while full
//   underflow_err_o             : sticky, resolve while empty
//
// state   | meaning
// --------+-----------------------------------------------------------
// MONITOR | normal operation; alarm low
// ALARM   | last window(s) too inaccurate; alarm high until a good window
module bp_accuracy_monitor #(
  parameter int PC_WIDTH     = 10,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_WIDTH    = 16,
  parameter int WINDOW       = 64,
  parameter int ALARM_THRESH = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  bp_accuracy_monitor_if.slave             bp_if,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_o,
  output logic [CNT_WIDTH-1:0]             total_count_o,
  output logic [CNT_WIDTH-1:0]             mispredict_count_o,
  output logic [$clog2(WINDOW+1)-1:0]      last_window_mispredicts_o,
  output logic                             alarm_o,
  output logic                             pc_mismatch_err_o,
  output logic                             overflow_err_o,
  output logic                             underflow_err_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WW = $clog2(WINDOW + 1);

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [WW-1:0] WINDOW_C = WW'(WINDOW);
  localparam logic [WW-1:0] THRESH_C = WW'(ALARM_THRESH);
  localparam logic [WW-1:0] HALF_C   = WW'(ALARM_THRESH / 2);

  typedef enum logic {
    MONITOR = 1'b0,
    ALARM   = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [PC_WIDTH-1:0] pc_mem_q    [FIFO_DEPTH];
  logic                taken_mem_q [FIFO_DEPTH];

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CNT_WIDTH-1:0] total_q, total_d;
  logic [CNT_WIDTH-1:0] mis_q, mis_d;
  logic [WW-1:0]        res_cnt_q, res_cnt_d;
  logic [WW-1:0]        win_mis_q, win_mis_d;
  logic [WW-1:0]        last_win_q, last_win_d;
  logic                 pc_err_q, pc_err_d;
  logic                 ovf_err_q, ovf_err_d;
  logic                 unf_err_q, unf_err_d;

  logic                 empty, full;
  logic                 pop, push;
  logic                 match, mispredict, win_done;
  logic [PC_WIDTH-1:0]  head_pc;
  logic                 head_taken;
  logic [WW-1:0]        res_cnt_inc, win_mis_inc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Buffer control and matching
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == DEPTH_C);
    pop        = bp_if.resolve_valid && !empty;
    // A pop frees the slot in the same cycle, so a full buffer still accepts.
    push       = bp_if.pred_valid && (!full || pop);
    head_pc    = pc_mem_q[rd_ptr_q];
    head_taken = taken_mem_q[rd_ptr_q];
    match      = pop && (head_pc == bp_if.resolve_pc);
    mispredict = match && (head_taken != bp_if.resolve_taken);

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // Counters, window accounting and sticky errors
  always_comb begin
    total_d     = total_q;
    mis_d       = mis_q;
    res_cnt_d   = res_cnt_q;
    win_mis_d   = win_mis_q;
    last_win_d  = last_win_q;
    res_cnt_inc = res_cnt_q + 1'b1;
    win_mis_inc = win_mis_q + WW'(mispredict);
    win_done    = match && (res_cnt_inc == WINDOW_C);

    if (match && (total_q != '1))    total_d = total_q + 1'b1;
    if (mispredict && (mis_q != '1)) mis_d   = mis_q + 1'b1;

    if (win_done) begin
      // The closing resolution's own mispredict belongs to this window.
      last_win_d = win_mis_inc;
      res_cnt_d  = '0;
      win_mis_d  = '0;
    end else if (match) begin
      res_cnt_d = res_cnt_inc;
      win_mis_d = win_mis_inc;
    end

    pc_err_d  = pc_err_q  | (pop && !match);
    ovf_err_d = ovf_err_q | (bp_if.pred_valid && full && !pop);
    unf_err_d = unf_err_q | (bp_if.resolve_valid && empty);
  end

  // Alarm FSM: trips at the threshold, releases only below half of it.
  always_comb begin
    state_d = state_q;
    if (win_done) begin
      case (state_q)
        MONITOR: if (win_mis_inc >= THRESH_C) state_d = ALARM;
        ALARM:   if (win_mis_inc <  HALF_C)   state_d = MONITOR;
        default: state_d = MONITOR;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= MONITOR;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      total_q    <= '0;
      mis_q      <= '0;
      res_cnt_q  <= '0;
      win_mis_q  <= '0;
      last_win_q <= '0;
      pc_err_q   <= 1'b0;
      ovf_err_q  <= 1'b0;
      unf_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      total_q    <= total_d;
      mis_q      <= mis_d;
      res_cnt_q  <= res_cnt_d;
      win_mis_q  <= win_mis_d;
      last_win_q <= last_win_d;
      pc_err_q   <= pc_err_d;
      ovf_err_q  <= ovf_err_d;
      unf_err_q  <= unf_err_d;
    end
  end

  // Entry storage needs no reset; only slots between the pointers are read.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      pc_mem_q[wr_ptr_q]    <= bp_if.pred_pc;
      taken_mem_q[wr_ptr_q] <= bp_if.pred_taken;
    end
  end

  assign fifo_count_o              = count_q;
  assign total_count_o             = total_q;
  assign mispredict_count_o        = mis_q;
  assign last_window_mispredicts_o = last_win_q;
  assign alarm_o                   = (state_q == ALARM);
  assign pc_mismatch_err_o         = pc_err_q;
  assign overflow_err_o            = ovf_err_q;
  assign underflow_err_o           = unf_err_q;

endmodule
